// File: rtl/gen_clk_pkg.sv
// Shared defaults and elaboration helpers for the 1 Hz clock-enable divider.
// Build option GEN_CLK_1HZ_SIM_FAST_EN is consumed by gen_clk_1hz_div.
package gen_clk_pkg;

  localparam int unsigned CLK_FREQ_HZ_DEFAULT = 50_000_000;
  localparam int unsigned OUT_FREQ_HZ_DEFAULT = 1;

  // Input cycles per output half-period; 0 flags an unusable configuration.
  function automatic int unsigned half_period(input int unsigned clk_hz,
                                              input int unsigned out_hz);
    if (out_hz == 0) return 0;
    return clk_hz / (2 * out_hz);
  endfunction

  // Counter width for values 0..hp-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned hp);
    if (hp <= 1) return 1;
    return $clog2(hp);
  endfunction

endpackage

// File: rtl/gen_clk_1hz_div_mod_n_counter.sv
// Modulo-N up counter (0..N-1) with a terminal-count flag, async active-high reset.
module mod_n_counter
  import gen_clk_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic clk_50MHz,
  input  logic rst,
  output logic tc_o
);

  localparam int unsigned CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_o = (cnt_q == LAST);

  // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tc_o) cnt_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gen_clk_1hz_div.sv
// 50%-duty square-wave divider with a one-cycle rising-edge tick enable.
// Define GEN_CLK_1HZ_SIM_FAST_EN to force HALF_PERIOD to 5 for simulation.
module gen_clk_1hz_div
  import gen_clk_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEFAULT,
  parameter int unsigned OUT_FREQ_HZ = OUT_FREQ_HZ_DEFAULT
) (
  input  logic clk_50MHz,
  input  logic rst,
  output logic clk_1Hz,
  output logic tick_1Hz
);

  localparam int unsigned HALF_PERIOD_CALC = half_period(CLK_FREQ_HZ, OUT_FREQ_HZ);
`ifdef GEN_CLK_1HZ_SIM_FAST_EN
  localparam int unsigned HALF_PERIOD = 5;
`else
  localparam int unsigned HALF_PERIOD = HALF_PERIOD_CALC;
`endif

  generate
    if (OUT_FREQ_HZ == 0 || HALF_PERIOD_CALC < 1 ||
        (CLK_FREQ_HZ % (2 * OUT_FREQ_HZ)) != 0) begin : g_bad_cfg
      $fatal(1, "gen_clk_1hz_div: CLK_FREQ_HZ must be a nonzero multiple of 2*OUT_FREQ_HZ");
    end
  endgenerate

  logic tc;
  logic clk_q, clk_d;
  logic tick_q, tick_d;

  mod_n_counter #(
    .N (HALF_PERIOD)
  ) u_cnt (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .tc_o      (tc)
  );

  // The tick is registered alongside the toggle so it lines up with the rising level.
  always_comb begin
    clk_d  = clk_q ^ tc;
    tick_d = tc & ~clk_q;
  end

  always_ff @(posedge clk_50MHz or posedge rst) begin
    if (rst) begin
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_1Hz  = clk_q;
  assign tick_1Hz = tick_q;

endmodule

// File: tb/tb_gen_clk_1hz_div.sv
// Directed bench for gen_clk_1hz_div at HALF_PERIOD=5 (CLK_FREQ_HZ=100, OUT_FREQ_HZ=10).
module tb_gen_clk_1hz_div;

  localparam int HP = 5;

  typedef struct {
    string tag;
    logic  clk_v;
    logic  tick_v;
  } exp_t;

  logic clk_50MHz = 1'b0;
  logic rst       = 1'b1;
  logic clk_1Hz;
  logic tick_1Hz;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  gen_clk_1hz_div #(
    .CLK_FREQ_HZ (100),
    .OUT_FREQ_HZ (10)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .clk_1Hz   (clk_1Hz),
    .tick_1Hz  (tick_1Hz)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  initial begin
    #200us;
    $display("FAIL watchdog: run did not complete (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  // Reference waveform: k rising edges since reset release.
  function automatic logic ref_clk(input int k);
    return logic'((k / HP) % 2);
  endfunction

  function automatic logic ref_tick(input int k);
    return (k > 0) && ((k % (2 * HP)) == HP);
  endfunction

  task automatic push(input string tag, input logic c, input logic t);
    exp_t e;
    e.tag    = tag;
    e.clk_v  = c;
    e.tick_v = t;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard: observed empty queue, required pending entry");
      return;
    end
    e = sb.pop_front();
    assert ({clk_1Hz, tick_1Hz} === {e.clk_v, e.tick_v}) else begin
      bad++;
      $error("FAIL %s: observed clk=%b tick=%b, required clk=%b tick=%b",
             e.tag, clk_1Hz, tick_1Hz, e.clk_v, e.tick_v);
    end
  endtask

  // Advance one rising edge and compare at the following falling edge.
  task automatic run_edge(input string tag, input logic c, input logic t);
    push(tag, c, t);
    @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    pop_check();
  endtask

  initial begin
    // Reset hold with the clock running.
    for (int i = 0; i < 4; i++) run_edge($sformatf("reset_hold%0d", i), 1'b0, 1'b0);

    // Release between edges; rises at 5,15,25 and falls at 10,20,30.
    rst = 1'b0;
    for (int k = 1; k <= 18; k++)
      run_edge($sformatf("run1_e%0d", k), ref_clk(k), ref_tick(k));

    // Edge 18 is the third edge of the high phase; reset mid-count.
    #2 rst = 1'b1;
    #1;
    push("async_reset", 1'b0, 1'b0);
    pop_check();
    for (int i = 0; i < 2; i++) run_edge($sformatf("mid_reset_hold%0d", i), 1'b0, 1'b0);

    rst = 1'b0;
    for (int k = 1; k <= 26; k++)
      run_edge($sformatf("run2_e%0d", k), ref_clk(k), ref_tick(k));

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed %0d leftover, required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
